multi_reg_seq_pp: RTL
=====================

MULTI_REG_SEQ_PP -- requirements
Module: multi_reg_seq_pp

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port ir_in, input, 16: instruction held in the decode-stage register; opcode ir_in[15:12], register list ir_in[7:0].
REQ-004 SHALL have port valid_in, input, 1: ir_in holds a real instruction (0 = bubble).
REQ-005 SHALL have port stall_in, input, 1: downstream hold; no sequencer state advances while high.
REQ-006 SHALL have port flush, input, 1: branch/jump squash of the decode stage.
REQ-007 SHALL have port regr, output, 3: register index for the current transfer beat.
REQ-008 SHALL have port comp, output, 1: current beat is the last LM/SM beat; 1 for any other instruction.
REQ-009 SHALL have port comp1, output, 1: current beat is the last LA/SA beat; 1 for any other instruction.
REQ-010 SHALL have port offs, output, 3: count of beats already completed for the current instruction (memory word offset).
REQ-011 SHALL have port fetch_stall, output, 1: freeze PC and IF/ID register; equals multi-beat instruction active and final-beat flag low.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; mask register mask_r[7:0]; counter cnt[2:0].
REQ-013 SHALL use source mask src = ir_in[7:0] in IDLE and src = mask_r in RUN.
REQ-014 SHALL, for LM (1100) or SM (1101) with valid_in, drive regr = lowest set bit index of src, comp = (popcount(src) <= 1), comp1 = 1.
REQ-015 SHALL, on an LM/SM edge with stall_in=0 and comp=0, load mask_r <= src with bit regr cleared, increment offs, enter/stay RUN.
REQ-016 SHALL, on an LM/SM edge with stall_in=0 and comp=1, enter IDLE, clear mask_r and offs.
REQ-017 SHALL treat an empty list (ir_in[7:0]=0) as one beat: regr=0, comp=1, fetch_stall=0, no state change.
REQ-018 SHALL, for LA (1110)/SA (1111) with valid_in, drive regr = cnt, comp1 = (cnt==7), comp=1; each unstalled edge increments cnt and offs, wrap at 7 to 0 and IDLE.
REQ-019 SHALL, for any other opcode or valid_in=0, drive regr=0, comp=1, comp1=1, offs=0, fetch_stall=0 and remain in IDLE.
REQ-020 SHALL hold all registered state and outputs unchanged while stall_in=1 (stall_in has priority over advance).
REQ-021 SHALL, when flush=1 on an edge, enter IDLE, clear mask_r, cnt, offs, regardless of stall_in.
REQ-022 SHALL produce outputs combinationally from state and ir_in; zero-cycle latency from ir_in to first beat.
REQ-023 SHALL take N cycles for a list of N set bits (N>=1), 8 cycles for LA/SA, absent stalls.

Reset
REQ-024 SHALL, while rst_n=0, force IDLE, mask_r=0, cnt=0, offs=0; outputs then follow REQ-019 or the IDLE first-beat rules.
REQ-025 SHALL abandon any in-progress sequence on reset assertion; no beat resumes after rst_n deasserts.

Configuration
REQ-026 SHALL honour macro MULTI_REG_LASA_EN: defined -> LA/SA sequenced per REQ-018; undefined -> LA/SA decode as REQ-019 (comp1=1, single beat), cnt logic absent.

Structure
REQ-027 SHALL place opcode constants OP_LM, OP_SM, OP_LA, OP_SA and the FSM state type in shared package pp_pkg.
REQ-028 SHALL instantiate sub-module prio_enc8 (8-bit lowest-set-bit encoder plus single-or-zero-bit flag) for regr/comp.

Verification
REQ-029 SHALL cover LM list 8'b1010_0101, no stall -> regr 0,2,5,7 over 4 cycles, offs 0..3, comp=1 only on 4th, fetch_stall 1,1,1,0.
REQ-030 SHALL cover SM list 8'b0000_1000 -> single beat regr=3, comp=1, fetch_stall=0, offs=0.
REQ-031 SHALL cover LM 8'hFF with stall_in high in beat 3 for 2 cycles -> regr=2 held 3 cycles, total 10 cycles, offs final 7.
REQ-032 SHALL cover LA with MULTI_REG_LASA_EN -> regr 0..7, comp1=1 only when regr=7; without macro -> comp1=1, regr=0 in one cycle.
REQ-033 SHALL cover flush during LM 8'hF0 beat 2 -> next cycle IDLE, offs=0, fetch_stall=0; and rst_n low mid-LA -> same state.
REQ-034 SHALL cover ADD (0001) and valid_in=0 with any ir_in -> comp=1, comp1=1, regr=0, fetch_stall=0.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared opcode constants and sequencer state type for the multi-register
// transfer sequencer (optional LA/SA sequencing: MULTI_REG_LASA_EN).
package pp_pkg;

  localparam logic [3:0] OP_LM = 4'b1100;
  localparam logic [3:0] OP_SM = 4'b1101;
  localparam logic [3:0] OP_LA = 4'b1110;
  localparam logic [3:0] OP_SA = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pp_state_e;

endpackage

// File: rtl/multi_reg_seq_pp_prio_enc8.sv
// 8-bit lowest-set-bit encoder with a "at most one bit set" flag; an all-zero
// vector encodes as index 0 with the flag set.
module prio_enc8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       le1
);

  logic [2:0] j;

  // Scan from the top so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    j   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      j = 3'(7 - i);
      if (vec[j]) idx = j;
    end
  end

  assign le1 = ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/multi_reg_seq_pp.sv
// Decode-stage sequencer for LM/SM register-list transfers and (when
// MULTI_REG_LASA_EN is defined) fixed 8-beat LA/SA transfers.
module multi_reg_seq_pp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir_in,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush,
  output logic [2:0]  regr,
  output logic        comp,
  output logic        comp1,
  output logic [2:0]  offs,
  output logic        fetch_stall
);

  import pp_pkg::*;

  pp_state_e  state;
  logic [7:0] mask_r;
  logic [2:0] offs_r;

  logic [3:0] opcode;
  logic       is_lmsm;
  logic [7:0] src;
  logic [2:0] enc_idx;
  logic       enc_le1;
  logic       unused_bits;

  assign opcode      = ir_in[15:12];
  assign is_lmsm     = valid_in && ((opcode == OP_LM) || (opcode == OP_SM));
  assign unused_bits = ^ir_in[11:8];

  // First beat decodes straight from the instruction; later beats use the
  // remaining mask.
  assign src = (state == ST_RUN) ? mask_r : ir_in[7:0];

  prio_enc8 u_enc (
    .vec (src),
    .idx (enc_idx),
    .le1 (enc_le1)
  );

`ifdef MULTI_REG_LASA_EN
  logic [2:0] cnt;
  logic       is_lasa;
  assign is_lasa = valid_in && ((opcode == OP_LA) || (opcode == OP_SA));
`endif

  always_comb begin
    regr        = '0;
    comp        = 1'b1;
    comp1       = 1'b1;
    offs        = '0;
    fetch_stall = 1'b0;
    if (is_lmsm) begin
      regr        = enc_idx;
      comp        = enc_le1;
      offs        = offs_r;
      fetch_stall = !enc_le1;
    end
`ifdef MULTI_REG_LASA_EN
    else if (is_lasa) begin
      regr        = cnt;
      comp1       = (cnt == 3'd7);
      offs        = offs_r;
      fetch_stall = (cnt != 3'd7);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mask_r <= '0;
      offs_r <= '0;
`ifdef MULTI_REG_LASA_EN
      cnt    <= '0;
`endif
    end else if (flush) begin
      state  <= ST_IDLE;
      mask_r <= '0;
      offs_r <= '0;
`ifdef MULTI_REG_LASA_EN
      cnt    <= '0;
`endif
    end else if (!stall_in) begin
      if (is_lmsm) begin
        if (!enc_le1) begin
          state  <= ST_RUN;
          mask_r <= src & ~(8'b1 << enc_idx);
          offs_r <= offs_r + 3'd1;
        end else begin
          state  <= ST_IDLE;
          mask_r <= '0;
          offs_r <= '0;
        end
      end
`ifdef MULTI_REG_LASA_EN
      else if (is_lasa) begin
        if (cnt == 3'd7) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          offs_r <= '0;
        end else begin
          state  <= ST_RUN;
          cnt    <= cnt + 3'd1;
          offs_r <= offs_r + 3'd1;
        end
      end
`endif
      else begin
        state  <= ST_IDLE;
        mask_r <= '0;
        offs_r <= '0;
`ifdef MULTI_REG_LASA_EN
        cnt    <= '0;
`endif
      end
    end
  end

endmodule
